// File: rtl/ds_adc_spi_readout.sv
// ---------------------------------------------------------------------------
// ds_adc_spi_readout
//
// Readout stage behind the two CIC decimators of the delta-sigma comparator
// ADC. Every decimation strobe captures the channel A and B words, together
// with a 3-bit sequence number, as one frame in a small FIFO. An external host
// drains the FIFO over a 4-wire SPI-style link (mode 0, MSB first).
//
// Frame shifted to the host (FRAME = 2*WIDTH+6 bits, MSB first):
//   {ovf, seq[2:0], 2'b10, a[WIDTH-1:0], b[WIDTH-1:0]}   valid frame
//   {ovf, {FRAME-1{1'b0}}}                               FIFO was empty
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   sample_a, sample_b   filtered channel words (two's complement, untouched)
//   sample_stb           one-cycle pulse, sample_a/sample_b valid this cycle
//   spi_cs_n, spi_sclk   host chip select / serial clock, asynchronous to clk
//   spi_miso             serial data to host
//   data_ready           FIFO non-empty
//   fifo_count           frames currently stored
//   overflow             sticky: at least one frame dropped since last reported
//
// Handshake: sample_stb is a valid with no ready. The block never
// back-pressures the decimators; a strobe that finds the FIFO full (and no pop
// in the same cycle) is dropped, still consumes a sequence number, and sets
// the sticky overflow flag, which is reported in the MSB of the next frame
// popped.
// ---------------------------------------------------------------------------
module ds_adc_spi_readout #(
  parameter int WIDTH       = 13,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           sample_a,
  input  logic [WIDTH-1:0]           sample_b,
  input  logic                       sample_stb,
  input  logic                       spi_cs_n,
  input  logic                       spi_sclk,
  output logic                       spi_miso,
  output logic                       data_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = 2 * WIDTH + 6;
  localparam int EW    = 2 * WIDTH + 3;  // stored entry: {seq, a, b}
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronisers and edge detection
  // -------------------------------------------------------------------------
  // cs_n flops reset high and sclk flops reset low so that reset itself never
  // looks like a select or a clock edge.
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   cs_d;
  logic                   sclk_d;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic       load_frame;
  logic       shift_en;
  logic [FRAME-1:0] shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cs_fall) state_d = S_SHIFT;
      S_SHIFT: if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // spi_miso is a mux of registers, so it becomes valid on the same edge as
  // the load (and the fifo_count decrement) rather than one edge later.
  always_comb begin
    load_frame = 1'b0;
    shift_en   = 1'b0;
    spi_miso   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        load_frame = cs_fall;
      end
      S_SHIFT: begin
        spi_miso = shift_reg[FRAME-1];
        shift_en = sclk_fall & ~cs_rise;
      end
      default: begin
        spi_miso = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [2:0]    seq_q;
  logic          ovf_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          do_pop;
  logic          do_write;
  logic          drop;
  logic [EW-1:0] rd_entry;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign do_pop     = load_frame & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a strobe into a full FIFO is
  // still accepted when the host is starting a read at that moment.
  assign do_write   = sample_stb & (~fifo_full | do_pop);
  assign drop       = sample_stb & fifo_full & ~do_pop;
  assign rd_entry   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {seq_q, sample_a, sample_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      seq_q   <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;

      unique case ({do_write, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Every strobe consumes a sequence number, so gaps in the sequence seen
      // by the host equal the number of dropped samples.
      if (sample_stb) seq_q <= seq_q + 3'd1;

      // A drop in the same cycle wins over the clear from a pop; an empty
      // frame reports the flag without clearing it.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (do_pop) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (load_frame) begin
      if (fifo_empty) begin
        shift_reg <= {ovf_q, {(FRAME-1){1'b0}}};
      end else begin
        shift_reg <= {ovf_q, rd_entry[EW-1 -: 3], 2'b10, rd_entry[2*WIDTH-1:0]};
      end
    end else if (shift_en) begin
      // Zeros fill in behind the frame, so extra clocks read as zeros.
      shift_reg <= {shift_reg[FRAME-2:0], 1'b0};
    end else if (state_q == S_SHIFT && cs_rise) begin
      // An aborted frame was already popped; drop whatever remains of it.
      shift_reg <= '0;
    end
  end

  assign data_ready = ~fifo_empty;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ds_adc_spi_readout.sv
// ---------------------------------------------------------------------------
// tb_ds_adc_spi_readout
//
// Self-checking bench for ds_adc_spi_readout at default parameters. Strobes
// push the expected FIFO entry (or the overflow flag) into a reference model;
// each SPI read pops the model to form the expected frame and compares it
// with the bits clocked out of spi_miso.
// ---------------------------------------------------------------------------
module tb_ds_adc_spi_readout;

  localparam int WIDTH = 13;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int FRAME = 2 * WIDTH + 6;
  localparam int EW    = 2 * WIDTH + 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sample_a = '0;
  logic [WIDTH-1:0] sample_b = '0;
  logic             sample_stb = 1'b0;
  logic             spi_cs_n = 1'b1;
  logic             spi_sclk = 1'b0;
  logic             spi_miso;
  logic             data_ready;
  logic [CW-1:0]    fifo_count;
  logic             overflow;

  always #5 clk = ~clk;

  ds_adc_spi_readout #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_a   (sample_a),
    .sample_b   (sample_b),
    .sample_stb (sample_stb),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_miso   (spi_miso),
    .data_ready (data_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic [2:0]    m_seq = 3'd0;
  logic          m_ovf = 1'b0;

  task automatic sb_clear();
    exp_q.delete();
    m_seq = 3'd0;
    m_ovf = 1'b0;
  endtask

  task automatic sb_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back({m_seq, a, b});
    else m_ovf = 1'b1;
    m_seq = m_seq + 3'd1;
  endtask

  task automatic sb_load(output logic [FRAME-1:0] f);
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      f = {m_ovf, e[EW-1 -: 3], 2'b10, e[2*WIDTH-1:0]};
      m_ovf = 1'b0;
    end else begin
      f = {m_ovf, {(FRAME-1){1'b0}}};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n      = 1'b0;
    spi_cs_n   = 1'b1;
    spi_sclk   = 1'b0;
    sample_stb = 1'b0;
    sb_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic drive_strobe(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    sample_a   = a;
    sample_b   = b;
    sample_stb = 1'b1;
    sb_push(a, b);
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  task automatic spi_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  task automatic spi_shift(input int nbits, input int half, output logic [63:0] data);
    data = '0;
    for (int i = 0; i < nbits; i++) begin
      data = {data[62:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic spi_end();
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic spi_read(input int nbits, input int half, output logic [63:0] data);
    spi_begin();
    spi_shift(nbits, half, data);
    spi_end();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [FRAME-1:0] f;
    logic [63:0]      d;
    apply_reset();
    checks++;
    if ({spi_miso, data_ready, fifo_count, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_values got=%b exp=0", {spi_miso, data_ready, fifo_count, overflow});
    end
    // Overfill so the loaded frame starts with a 1, then reset mid-frame.
    for (int i = 0; i < 5; i++) drive_strobe(WIDTH'($urandom), WIDTH'($urandom));
    sb_load(f);
    spi_begin();
    checks++;
    if (spi_miso !== f[FRAME-1]) begin
      failures++;
      $display("FAIL pre_reset_miso got=%b exp=%b", spi_miso, f[FRAME-1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_miso, data_ready, fifo_count, overflow} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0", {spi_miso, data_ready, fifo_count, overflow});
    end
    spi_cs_n = 1'b1;
    sb_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    sb_load(f);
    spi_read(32, 4, d);
    checks++;
    if (d[FRAME-1:0] !== f || d[31:0] !== 32'h0000_0000) begin
      failures++;
      $display("FAIL empty_read_after_reset got=%h exp=%h", d[FRAME-1:0], f);
    end
  endtask

  task automatic test_single_capture();
    logic [FRAME-1:0] f;
    logic [63:0]      d;
    apply_reset();
    drive_strobe(13'h0ABC, 13'h1F01);
    checks++;
    if (fifo_count !== CW'(1) || data_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_count got=%0d/%b exp=1/1", fifo_count, data_ready);
    end
    sb_load(f);
    spi_read(32, 4, d);
    checks++;
    if (d[FRAME-1:0] !== f) begin
      failures++;
      $display("FAIL single_frame got=%h exp=%h", d[FRAME-1:0], f);
    end
    // {0, 000, 10, 0_1010_1011_1100, 1_1111_0000_0001}
    checks++;
    if (d[31:0] !== 32'h0957_9F01) begin
      failures++;
      $display("FAIL single_frame_const got=%h exp=09579f01", d[31:0]);
    end
    checks++;
    if (fifo_count !== '0 || data_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got=%0d/%b exp=0/0", fifo_count, data_ready);
    end
  endtask

  task automatic test_overflow();
    logic [FRAME-1:0] f;
    logic [63:0]      d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_strobe(WIDTH'($urandom), WIDTH'($urandom));
      if (i == 3) begin
        checks++;
        if (fifo_count !== CW'(4) || overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_at_full got=%0d/%b exp=4/0", fifo_count, overflow);
        end
      end
      if (i == 4) begin
        checks++;
        if (fifo_count !== CW'(4) || overflow !== 1'b1) begin
          failures++;
          $display("FAIL ovf_after_drop got=%0d/%b exp=4/1", fifo_count, overflow);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      sb_load(f);
      spi_read(32, 4, d);
      checks++;
      if (d[FRAME-1:0] !== f) begin
        failures++;
        $display("FAIL ovf_read%0d got=%h exp=%h", i, d[FRAME-1:0], f);
      end
      checks++;
      if (d[FRAME-2 -: 3] !== 3'(i) || d[FRAME-1] !== (i == 0)) begin
        failures++;
        $display("FAIL ovf_seq%0d got=%0d/%b exp=%0d/%b", i, d[FRAME-2 -: 3], d[FRAME-1], i, (i == 0));
      end
      if (i == 0) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
      end
    end
    drive_strobe(WIDTH'($urandom), WIDTH'($urandom));
    sb_load(f);
    spi_read(32, 4, d);
    checks++;
    if (d[FRAME-1:0] !== f || d[FRAME-2 -: 3] !== 3'd6) begin
      failures++;
      $display("FAIL ovf_next_seq got=%h exp=%h (seq 6)", d[FRAME-1:0], f);
    end
  endtask

  task automatic test_full_pop();
    logic [FRAME-1:0] f;
    logic [63:0]      d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    apply_reset();
    for (int i = 0; i < 4; i++) drive_strobe(WIDTH'($urandom), WIDTH'($urandom));
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    sb_load(f);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (SYNC) @(negedge clk);
    // Strobe lands on the edge where the synchronised cs_n fall pops the head.
    sample_a   = a;
    sample_b   = b;
    sample_stb = 1'b1;
    sb_push(a, b);
    @(negedge clk);
    sample_stb = 1'b0;
    checks++;
    if (fifo_count !== CW'(4) || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_count got=%0d/%b exp=4/0", fifo_count, overflow);
    end
    repeat (4) @(negedge clk);
    spi_shift(32, 4, d);
    spi_end();
    checks++;
    if (d[FRAME-1:0] !== f) begin
      failures++;
      $display("FAIL full_pop_head got=%h exp=%h", d[FRAME-1:0], f);
    end
    for (int i = 0; i < 4; i++) begin
      sb_load(f);
      spi_read(32, 4, d);
      checks++;
      if (d[FRAME-1:0] !== f) begin
        failures++;
        $display("FAIL full_pop_read%0d got=%h exp=%h", i, d[FRAME-1:0], f);
      end
    end
    checks++;
    if (d[2*WIDTH-1:0] !== {a, b} || fifo_count !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_last got=%h/%0d/%b exp=%h/0/0", d[2*WIDTH-1:0], fifo_count, overflow, {a, b});
    end
  endtask

  task automatic test_abort_overrun();
    logic [FRAME-1:0] f;
    logic [63:0]      d;
    apply_reset();
    for (int i = 0; i < 3; i++) drive_strobe(WIDTH'($urandom), WIDTH'($urandom));
    sb_load(f);
    spi_begin();
    spi_shift(10, 4, d);
    spi_end();
    checks++;
    if (d[9:0] !== f[FRAME-1 -: 10]) begin
      failures++;
      $display("FAIL abort_partial got=%h exp=%h", d[9:0], f[FRAME-1 -: 10]);
    end
    sb_load(f);
    spi_read(32, 4, d);
    checks++;
    if (d[FRAME-1:0] !== f) begin
      failures++;
      $display("FAIL abort_next got=%h exp=%h", d[FRAME-1:0], f);
    end
    sb_load(f);
    spi_read(FRAME + 8, 4, d);
    checks++;
    if (d[FRAME+7:0] !== {f, 8'h00}) begin
      failures++;
      $display("FAIL overrun got=%h exp=%h", d[FRAME+7:0], {f, 8'h00});
    end
    checks++;
    if (fifo_count !== '0) begin
      failures++;
      $display("FAIL overrun_count got=%0d exp=0", fifo_count);
    end
  endtask

  task automatic test_random();
    logic [FRAME-1:0] f;
    logic [63:0]      d;
    int               n;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 3);
      for (int s = 0; s < n; s++) begin
        drive_strobe(WIDTH'($urandom), WIDTH'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if ($urandom_range(0, 3) != 0) begin
        sb_load(f);
        spi_read(32, $urandom_range(4, 6), d);
        checks++;
        if (d[FRAME-1:0] !== f) begin
          failures++;
          $display("FAIL random_read%0d got=%h exp=%h", it, d[FRAME-1:0], f);
        end
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      sb_load(f);
      spi_read(32, 4, d);
      checks++;
      if (d[FRAME-1:0] !== f) begin
        failures++;
        $display("FAIL random_drain%0d got=%h exp=%h", i, d[FRAME-1:0], f);
      end
    end
    checks++;
    if (fifo_count !== '0 || data_ready !== 1'b0 || overflow !== m_ovf) begin
      failures++;
      $display("FAIL random_final got=%0d/%b/%b exp=0/0/%b", fifo_count, data_ready, overflow, m_ovf);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_capture();
    test_overflow();
    test_full_pop();
    test_abort_overrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
